systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_ctrl.sv | 130 +++++++++++++
 tb/tb_systolic_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// Sequencer for a SIZE x SIZE weight-stationary systolic array: weight load, activation stream, drain.
// Optional cycle counter output perf_cycles is enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl #(
  parameter int SIZE  = 8,
  parameter int ROW_W = 8,
  localparam int AW   = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int PW   = 2 * SIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [ROW_W-1:0] act_rows,
  output logic             Weight_in_valid,
  output logic [AW-1:0]    wgt_rd_addr,
  output logic             act_rd_en,
  output logic [ROW_W-1:0] act_rd_addr,
  output logic [SIZE-1:0]  col_valid,
  output logic             busy,
  output logic             done
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_wgt_addr, w_wgt_addr_nxt;
  logic [ROW_W-1:0] r_act_addr, w_act_addr_nxt;
  logic [ROW_W-1:0] r_rows, w_rows_nxt;
  // Bit k is the STREAM strobe delayed k+1 cycles; column c taps delay SIZE+1+c.
  logic [PW-1:0]    r_pipe, w_pipe_nxt;

  // NOTE: every signal driven here gets a default before the case, so no latch can be inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_wgt_addr_nxt  = r_wgt_addr;
    w_act_addr_nxt  = r_act_addr;
    w_rows_nxt      = r_rows;
    w_pipe_nxt      = {r_pipe[PW-2:0], (r_state == S_STREAM)};
    Weight_in_valid = 1'b0;
    act_rd_en       = 1'b0;
    done            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && (act_rows != '0)) begin
          w_state_nxt    = S_LOAD_W;
          w_wgt_addr_nxt = AW'(SIZE - 1);
          w_rows_nxt     = act_rows;
        end
      end
      S_LOAD_W: begin
        Weight_in_valid = 1'b1;
        if (r_wgt_addr == '0) w_state_nxt = S_STREAM;
        else                  w_wgt_addr_nxt = r_wgt_addr - AW'(1);
      end
      S_STREAM: begin
        act_rd_en = 1'b1;
        if (r_act_addr == (r_rows - ROW_W'(1))) begin
          w_state_nxt    = S_DRAIN;
          w_act_addr_nxt = '0;
        end else begin
          w_act_addr_nxt = r_act_addr + ROW_W'(1);
        end
      end
      S_DRAIN: begin
        // Leave once the last valid has shifted out of the top column tap.
        if (w_pipe_nxt == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt    = S_IDLE;
      w_wgt_addr_nxt = '0;
      w_act_addr_nxt = '0;
      w_pipe_nxt     = '0;
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign col_valid   = r_pipe[PW-1:SIZE];
  assign wgt_rd_addr = r_wgt_addr;
  assign act_rd_addr = r_act_addr;

  // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wgt_addr <= '0;
      r_act_addr <= '0;
      r_rows     <= '0;
      r_pipe     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wgt_addr <= w_wgt_addr_nxt;
      r_act_addr <= w_act_addr_nxt;
      r_rows     <= w_rows_nxt;
      r_pipe     <= w_pipe_nxt;
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] r_perf;
  logic        w_accept;

  assign w_accept    = (r_state == S_IDLE) && start && (act_rows != '0);
  assign perf_cycles = r_perf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_perf <= '0;
    else if (w_accept)               r_perf <= '0;
    else if (busy && (r_perf != '1)) r_perf <= r_perf + 32'd1;
  end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl against a tile-timeline reference model.
// Also checks perf_cycles when compiled with SYSTOLIC_CTRL_PERF_EN.
module tb_systolic_ctrl;
  localparam int SIZE  = 8;
  localparam int ROW_W = 8;
  localparam int AW    = $clog2(SIZE);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [ROW_W-1:0] act_rows;
  logic             Weight_in_valid;
  logic [AW-1:0]    wgt_rd_addr;
  logic             act_rd_en;
  logic [ROW_W-1:0] act_rd_addr;
  logic [SIZE-1:0]  col_valid;
  logic             busy;
  logic             done;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0]      perf_cycles;
`endif

  systolic_ctrl #(.SIZE(SIZE), .ROW_W(ROW_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .act_rows        (act_rows),
    .Weight_in_valid (Weight_in_valid),
    .wgt_rd_addr     (wgt_rd_addr),
    .act_rd_en       (act_rd_en),
    .act_rd_addr     (act_rd_addr),
    .col_valid       (col_valid),
    .busy            (busy),
    .done            (done)
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    .perf_cycles     (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a tile is a timeline indexed by k, k=0 being the first weight-load cycle.
  bit          m_active = 0;
  int          m_k      = 0;
  int          m_rows   = 0;
  longint      m_perf   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic            e_wiv, e_ren, e_busy, e_done;
    logic [AW-1:0]   e_waddr;
    logic [ROW_W-1:0] e_raddr;
    logic [SIZE-1:0] e_col;
    int k, d;
    k       = m_k;
    e_wiv   = m_active && (k < SIZE);
    e_waddr = e_wiv ? AW'(SIZE - 1 - k) : '0;
    e_ren   = m_active && (k >= SIZE) && (k < SIZE + m_rows);
    e_raddr = e_ren ? ROW_W'(k - SIZE) : '0;
    for (int c = 0; c < SIZE; c++) begin
      d        = k - (2 * SIZE + 1 + c);
      e_col[c] = m_active && (d >= 0) && (d < m_rows);
    end
    e_busy = m_active;
    e_done = m_active && (k == 3 * SIZE + m_rows);
    check("weight_in_valid", 64'(Weight_in_valid), 64'(e_wiv));
    check("wgt_rd_addr",     64'(wgt_rd_addr),     64'(e_waddr));
    check("act_rd_en",       64'(act_rd_en),       64'(e_ren));
    check("act_rd_addr",     64'(act_rd_addr),     64'(e_raddr));
    check("col_valid",       64'(col_valid),       64'(e_col));
    check("busy",            64'(busy),            64'(e_busy));
    check("done",            64'(done),            64'(e_done));
    check("wiv_ren_exclusive", 64'(Weight_in_valid & act_rd_en), 64'(0));
`ifdef SYSTOLIC_CTRL_PERF_EN
    check("perf_cycles", 64'(perf_cycles), 64'(m_perf));
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check at the falling edge.
  task automatic step(input logic s, input logic a, input logic [ROW_W-1:0] rows);
    bit accept;
    start    = s;
    abort    = a;
    act_rows = rows;
    accept   = !m_active && s && (rows != 0);
    if (accept)                           m_perf = 0;
    else if (m_active && m_perf < 64'hFFFF_FFFF) m_perf++;
    if (m_active) begin
      if (a || (m_k == 3 * SIZE + m_rows)) m_active = 0;
      else                                 m_k++;
    end else if (accept) begin
      m_active = 1;
      m_k      = 0;
      m_rows   = int'(rows);
    end
    if (!m_active) m_k = 0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_outputs();
  endtask

  task automatic run_to_end(input logic [ROW_W-1:0] rows);
    while (m_active) step(1'b0, 1'b0, rows);
  endtask

  initial begin
    logic [ROW_W-1:0] r;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    act_rows = '0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'd0);

    // Baseline 4-row tile, including the perf total at completion.
    step(1'b1, 1'b0, 8'd4);
    run_to_end(8'd4);
`ifdef SYSTOLIC_CTRL_PERF_EN
    check("perf_total_4rows", 64'(perf_cycles), 64'(3 * SIZE + 4 + 1));
`endif
    step(1'b0, 1'b0, 8'd4);

    // Zero-row start is ignored.
    repeat (5) step(1'b1, 1'b0, 8'd0);

    // Start and act_rows change during the third STREAM cycle must not disturb the tile.
    step(1'b1, 1'b0, 8'd4);
    while (m_k < SIZE + 2) step(1'b0, 1'b0, 8'd4);
    step(1'b1, 1'b0, 8'd9);
    run_to_end(8'd9);
    step(1'b0, 1'b0, 8'd9);

    // Abort on the fifth LOAD_W cycle, then a clean full tile.
    step(1'b1, 1'b0, 8'd4);
    while (m_k < 4) step(1'b0, 1'b0, 8'd4);
    step(1'b0, 1'b1, 8'd4);
    step(1'b0, 1'b0, 8'd4);
    step(1'b1, 1'b0, 8'd4);
    run_to_end(8'd4);
    step(1'b0, 1'b0, 8'd4);

    // Random tiles with start spam, act_rows churn and occasional aborts.
    for (int t = 0; t < 8; t++) begin
      r = ROW_W'($urandom_range(1, 20));
      step(1'b1, 1'b0, r);
      while (m_active)
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0), ROW_W'($urandom));
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, '0);
    end

    // Asynchronous reset in the middle of DRAIN.
    step(1'b1, 1'b0, 8'd3);
    while (m_k < SIZE + 3 + 5) step(1'b0, 1'b0, 8'd3);
    #2 rst_n = 1'b0;
    #1;
    m_active = 0;
    m_k      = 0;
    m_perf   = 0;
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'd5);
    check("start_after_reset", 64'(busy), 64'(1));
    run_to_end(8'd5);
    step(1'b0, 1'b0, 8'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
